// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared types and requester IDs for the single-port RAM arbiter
package spram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/spram_arb_pick.sv
// rtl/spram_arb_pick.sv - combinational round-robin pick with burst-owner override
module spram_arb_pick
  import spram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  input  owner_e     i_owner,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_owner)
      OWN_A:   o_gnt[REQ_A] = i_req[REQ_A];
      OWN_B:   o_gnt[REQ_B] = i_req[REQ_B];
      default: begin
        // A tie goes to whoever did not win last time
        if (&i_req) o_gnt = (i_last_gnt == REQ_B) ? 2'b01 : 2'b10;
        else        o_gnt = i_req;
      end
    endcase
  end

endmodule

// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester round-robin arbiter with locked bursts for a single-port RAM
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_lock,
  input  logic                  a_we,
  input  logic [ADD_WIDTH-1:0]  a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_lock,
  input  logic                  b_we,
  input  logic [ADD_WIDTH-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADD_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int             BW       = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BEAT_MAX = BW'(MAX_BURST);

  owner_e                r_state;
  owner_e                w_state_nxt;
  logic                  r_last_gnt;
  logic                  w_last_gnt_nxt;
  logic [BW-1:0]         r_beat;
  logic [BW-1:0]         w_beat_nxt;
  logic [BW-1:0]         w_beat_inc;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic [ADD_WIDTH-1:0]  r_addr_hold;
  logic [DATA_WIDTH-1:0] r_wdata_hold;

  owner_e                w_owner;
  logic [1:0]            w_pick;
  logic [1:0]            w_gnt;
  logic                  w_win;
  logic                  w_win_lock;

  // Ownership only binds while the owner keeps lock asserted
  always_comb begin
    w_owner = IDLE;
    if (r_state == OWN_A && a_lock)      w_owner = OWN_A;
    else if (r_state == OWN_B && b_lock) w_owner = OWN_B;
  end

  spram_arb_pick u_pick (
    .i_req      ({b_req, a_req}),
    .i_last_gnt (r_last_gnt),
    .i_owner    (w_owner),
    .o_gnt      (w_pick)
  );

  assign w_gnt      = w_pick & {2{reset}};
  assign w_win      = w_gnt[REQ_B];
  assign w_win_lock = w_win ? b_lock : a_lock;
  assign w_beat_inc = r_beat + BW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_gnt   <= REQ_B;
      r_beat       <= '0;
      r_a_rvalid   <= 1'b0;
      r_b_rvalid   <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_beat     <= w_beat_nxt;
      r_a_rvalid <= w_gnt[REQ_A] & ~a_we;
      r_b_rvalid <= w_gnt[REQ_B] & ~b_we;
      if (|w_gnt) begin
        r_addr_hold  <= ram_addr;
        r_wdata_hold <= ram_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_last_gnt_nxt = r_last_gnt;
    w_beat_nxt     = r_beat;
    if (w_owner != IDLE) begin
      if (|w_gnt) begin
        w_last_gnt_nxt = w_win;
        if (w_beat_inc == BEAT_MAX) begin
          w_state_nxt = IDLE;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt = w_beat_inc;
        end
      end
    end else begin
      w_state_nxt = IDLE;
      w_beat_nxt  = '0;
      if (|w_gnt) begin
        w_last_gnt_nxt = w_win;
        if (w_win_lock && MAX_BURST > 1) begin
          w_state_nxt = w_win ? OWN_B : OWN_A;
          w_beat_nxt  = BW'(1);
        end
      end
    end
  end

  always_comb begin
    a_gnt     = w_gnt[REQ_A];
    b_gnt     = w_gnt[REQ_B];
    ram_we    = 1'b0;
    ram_addr  = r_addr_hold;
    ram_wdata = r_wdata_hold;
    if (w_gnt[REQ_A]) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (w_gnt[REQ_B]) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  // Gating with reset hides a read return that would land in a reset cycle
  assign a_rvalid = r_a_rvalid & reset;
  assign b_rvalid = r_b_rvalid & reset;
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single_port_ram instance. It gives one requester per cycle access to the single RAM port, using round-robin arbitration. It supports locked bursts capped at MAX_BURST beats, and returns 1-cycle-latency read data to the requester that issued the read.

Parameters:
DATA_WIDTH, 8, RAM word width
ADD_WIDTH, 4, RAM address width
MAX_BURST, 4, max consecutive granted beats under lock (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
a_req  in  1  requester A access request (held until granted)
a_lock  in  1  requester A burst lock request
a_we  in  1  A: 1=write, 0=read
a_addr  in  ADD_WIDTH  A address
a_wdata  in  DATA_WIDTH  A write data
a_gnt  out  1  A access accepted this cycle
a_rvalid  out  1  A read data valid
a_rdata  out  DATA_WIDTH  A read data
b_req, b_lock, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
ram_we  out  1  RAM write enable
ram_addr  out  ADD_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM registered read data (valid the cycle after the address)

Behaviour:
- Transfer: an access happens in a cycle where x_req && x_gnt.
  - x_gnt is combinational from current state and requests.
  - At most one gnt is high per cycle.
  - gnt never asserts without req.
- RAM drive:
  - When a requester is granted, ram_addr and ram_wdata are that requester's signals, and ram_we = x_we.
  - With no grant: ram_we=0, and ram_addr/ram_wdata hold their last granted values (registered hold).
- Read return:
  - A granted read in cycle T gives x_rvalid=1 in T+1 only.
  - x_rdata = ram_rdata (combinational passthrough), meaningful only while x_rvalid=1.
  - A write produces no rvalid.
- State: IDLE, OWN_A, OWN_B. Registers: last_gnt (0=A, 1=B) and beat_cnt, width $clog2(MAX_BURST+1).
- IDLE:
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the one not equal to last_gnt is granted.
  - last_gnt updates on every grant.
  - If the winner has lock=1 and MAX_BURST>1: next state OWN_winner, beat_cnt=1.
- OWN_x, lock_x=1:
  - Only x may be granted; the other requester is blocked even if idle cycles occur.
  - Each grant increments beat_cnt.
  - The grant that brings beat_cnt to MAX_BURST makes the next state IDLE, with last_gnt=x so the other requester wins a tie next.
  - req_x=0 with lock_x=1: no grant, state held, beat_cnt unchanged.
- OWN_x, lock_x=0: the cycle arbitrates exactly as IDLE (last_gnt=x), and the next state follows IDLE rules.
- Reset (reset==0 at a rising edge):
  - state=IDLE, last_gnt=B (so A wins the first tie), beat_cnt=0.
  - a_rvalid=b_rvalid=0, ram_addr=0, ram_wdata=0, ram_we=0.
  - While reset=0, all gnt outputs are 0.
  - Reset mid-burst or with a read in flight discards ownership and the pending rvalid; no rvalid appears after reset.
- Same address, consecutive write then read: the read returns the new data (RAM is write-before-read by sequencing; no bypass in the arbiter).

Decomposition:
- Package spram_arb_pkg: owner state enum (IDLE/OWN_A/OWN_B) and requester ID localparams REQ_A=0, REQ_B=1.
- One combinational sub-module, spram_arb_pick: inputs req[1:0], last_gnt, owner; output one-hot grant.
- The top holds the FSM, beat counter, rvalid pipeline and RAM mux.

Test Plan:
- Reset, then A write addr 3 data 0x5A, then A read addr 3 -> a_gnt in both cycles, a_rvalid=1 one cycle after the read grant, a_rdata=0x5A, b_rvalid=0.
- A and B both request continuously (no lock) from reset -> grants alternate A,B,A,B; B's reads return only on b_rvalid.
- A lock=1 with 6 back-to-back writes, B req high throughout, MAX_BURST=4 -> A gets 4 grants, B is granted in cycle 5, then A resumes.
- A locked, A drops req for 2 cycles while B requests -> no grants in those cycles; B is granted only after a_lock falls or the burst cap is reached.
- A read granted in cycle T, reset low in T+1 -> a_rvalid=0 in T+1 and after; state IDLE; first tie after release goes to A.
- Write by B to addr 15 = 0xFF, then read by A at addr 15 -> a_rdata=0xFF; address wrap/top-of-range handled with no aliasing to addr 0.
